rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_reader_pkg.sv | 6 +
 rtl/rom_stream_reader_if.sv | 7 +
 rtl/rom_stream_reader_fifo2.sv | 24 ++
 rtl/rom_stream_reader.sv | 71 +++++++
 tb/tb_rom_stream_reader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_stream_reader_pkg.sv
// rom_stream_reader_pkg: ROM geometry and reader FSM encoding shared with the ROM instance
package rom_stream_reader_pkg;
  localparam int ROM_ADDR_W = 5;
  localparam int ROM_DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: valid/ready byte stream with burst-last marker
interface rom_stream_reader_if #(parameter int DATA_W = rom_stream_reader_pkg::ROM_DATA_W);
  logic [DATA_W-1:0] out_data;
  logic out_valid, out_ready, out_last;
  modport master(output out_data, out_valid, out_last, input out_ready);
  modport slave(input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/rom_stream_reader_fifo2.sv
// stream_fifo2: 2-entry register FIFO, head held in rdata, same-cycle push/pop
module stream_fifo2 import rom_stream_reader_pkg::*; #(
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] d1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata <= '0;
      d1    <= '0;
      count <= '0;
    end else begin
      rdata <= pop ? ((push && count == 2'd1) ? wdata : d1) : ((push && count == 2'd0) ? wdata : rdata);
      d1    <= (push && (count == 2'd2 || (count == 2'd1 && !pop))) ? wdata : d1;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: sequences ROM addresses and streams a burst of bytes over valid/ready
module rom_stream_reader import rom_stream_reader_pkg::*; #(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  rom_stream_reader_if.master s
);
  state_t            state;
  logic [ADDR_W:0]   issue_left, beat_left;
  logic              inflight, pop, issue;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic [DATA_W-1:0] head;
  // credit: buffered plus outstanding bytes, after this cycle's pop, must leave room
  assign pop         = s.out_valid && s.out_ready;
  assign occ         = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue       = state == RUN && issue_left != '0 && occ < 3'd2;
  assign s.out_valid = count != 2'd0;
  assign s.out_data  = head;
  assign s.out_last  = s.out_valid && beat_left == (ADDR_W+1)'(1);
  stream_fifo2 #(.DATA_W(DATA_W)) fifo (
    .clk(clk), .reset(reset), .push(inflight), .pop(pop),
    .wdata(rom_data), .rdata(head), .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      inflight   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      if (state == IDLE) begin
        done <= start && len == '0;
        if (start && len != '0) begin
          rom_addr   <= start_addr;
          issue_left <= len;
          beat_left  <= len;
          busy       <= 1'b1;
          state      <= RUN;
        end
      end else begin
        if (issue) begin
          rom_addr   <= rom_addr + ADDR_W'(1);
          issue_left <= issue_left - (ADDR_W+1)'(1);
          if (issue_left == (ADDR_W+1)'(1)) state <= DRAIN;
        end
        if (pop) begin
          beat_left <= beat_left - (ADDR_W+1)'(1);
          if (beat_left == (ADDR_W+1)'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed scenario tasks against a 32x8 registered ROM model
module tb_rom_stream_reader;
  logic       clk = 0, reset = 0, start = 0;
  logic [4:0] start_addr = 0;
  logic [5:0] len = 0;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic       busy, done;
  logic [7:0] mem [32];
  int errors = 0, checks = 0;

  rom_stream_reader_if #(.DATA_W(8)) s();
  rom_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done), .s(s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [4:0] a, input logic [5:0] n);
    start = 1; start_addr = a; len = n;
    tick();
    start = 0;
  endtask

  task automatic test_reset;
    tick(); tick();
    reset = 1;
    #1;
    checks++;
    if ({rom_addr, s.out_data, s.out_valid, s.out_last, busy, done} !== 17'd0) begin
      errors++; $display("FAIL reset_values: got addr=%h data=%h v=%b l=%b busy=%b done=%b, want all 0",
        rom_addr, s.out_data, s.out_valid, s.out_last, busy, done);
    end
    tick();
    reset = 0;
    tick();
    checks++;
    if ({s.out_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got v=%b busy=%b done=%b, want 000", s.out_valid, busy, done);
    end
  endtask

  task automatic test_basic;
    logic ev;
    s.out_ready = 1;
    kick(5'd3, 6'd4);
    for (int c = 1; c <= 8; c++) begin
      ev = c >= 3 && c <= 6;
      checks++;
      if ({s.out_valid, s.out_last, done, busy} !== {ev, c == 6, c == 7, c <= 6}) begin
        errors++; $display("FAIL basic_ctrl c%0d: got v=%b l=%b done=%b busy=%b, want %b%b%b%b",
          c, s.out_valid, s.out_last, done, busy, ev, c == 6, c == 7, c <= 6);
      end
      if (ev) begin
        checks++;
        if (s.out_data !== 8'(8'h40 + c)) begin
          errors++; $display("FAIL basic_data c%0d: got %h want %h", c, s.out_data, 8'(8'h40 + c));
        end
      end
      if (c <= 4) begin
        checks++;
        if (rom_addr !== 5'(2 + c)) begin
          errors++; $display("FAIL basic_addr c%0d: got %0d want %0d", c, rom_addr, 5'(2 + c));
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap;
    logic [4:0] a;
    s.out_ready = 1;
    kick(5'd30, 6'd4);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) begin
        checks++;
        if (rom_addr !== 5'(29 + c)) begin
          errors++; $display("FAIL wrap_addr c%0d: got %0d want %0d", c, rom_addr, 5'(29 + c));
        end
      end
      if (c >= 3 && c <= 6) begin
        a = 5'(27 + c);
        checks++;
        if (!s.out_valid || s.out_data !== 8'h40 + {3'b0, a}) begin
          errors++; $display("FAIL wrap_data c%0d: got v=%b %h want %h", c, s.out_valid, s.out_data, 8'h40 + {3'b0, a});
        end
      end
      if (c == 7) begin
        checks++;
        if (done !== 1'b1) begin
          errors++; $display("FAIL wrap_done: got %b want 1", done);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    logic [9:0] hv;
    logic       held, fin;
    int k;
    pat = 4'b1001; held = 0; fin = 0; k = 0; hv = '0;
    s.out_ready = 1;
    kick(5'd0, 6'd8);
    for (int cyc = 1; cyc < 80 && !fin; cyc++) begin
      s.out_ready = pat[cyc % 4];
      if (held) begin
        checks++;
        if ({s.out_valid, s.out_last, s.out_data} !== hv) begin
          errors++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, {s.out_valid, s.out_last, s.out_data}, hv);
        end
      end
      if (s.out_valid && s.out_ready) begin
        checks++;
        if (s.out_data !== 8'(8'h40 + k) || s.out_last !== (k == 7)) begin
          errors++; $display("FAIL bp_beat%0d: got %h last=%b want %h last=%b", k, s.out_data, s.out_last, 8'(8'h40 + k), k == 7);
        end
        k++;
      end
      held = s.out_valid && !s.out_ready;
      hv = {s.out_valid, s.out_last, s.out_data};
      if (done) fin = 1;
      tick();
    end
    checks++;
    if (k !== 8 || !fin) begin
      errors++; $display("FAIL bp_count: got beats=%0d done=%b want 8 and 1", k, fin);
    end
  endtask

  task automatic test_stall_all;
    logic fin;
    int k;
    fin = 0; k = 0;
    s.out_ready = 0;
    kick(5'd5, 6'd8);
    repeat (9) tick();
    checks++;
    if (rom_addr !== 5'd7 || s.out_valid !== 1'b1 || s.out_data !== 8'h45) begin
      errors++; $display("FAIL stall_freeze: got addr=%0d v=%b data=%h want 7 1 45", rom_addr, s.out_valid, s.out_data);
    end
    s.out_ready = 1;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      if (s.out_valid) begin
        checks++;
        if (s.out_data !== 8'(8'h45 + k)) begin
          errors++; $display("FAIL stall_beat%0d: got %h want %h", k, s.out_data, 8'(8'h45 + k));
        end
        k++;
      end
      if (done) fin = 1;
      tick();
    end
    checks++;
    if (k !== 8 || !fin) begin
      errors++; $display("FAIL stall_count: got beats=%0d done=%b want 8 and 1", k, fin);
    end
  endtask

  task automatic test_len0_ignored;
    s.out_ready = 1;
    kick(5'd9, 6'd0);
    checks++;
    if ({done, busy, s.out_valid} !== 3'b100) begin
      errors++; $display("FAIL len0_c1: got done=%b busy=%b v=%b want 100", done, busy, s.out_valid);
    end
    tick();
    checks++;
    if ({done, busy, s.out_valid} !== 3'b000) begin
      errors++; $display("FAIL len0_c2: got done=%b busy=%b v=%b want 000", done, busy, s.out_valid);
    end
    kick(5'd3, 6'd4);
    tick();
    start = 1; start_addr = 5'd20; len = 6'd2;
    tick();
    start = 0;
    for (int c = 3; c <= 8; c++) begin
      checks++;
      if ({s.out_valid, s.out_last, done} !== {c <= 6, c == 6, c == 7} || rom_addr === 5'd20) begin
        errors++; $display("FAIL ignore_ctrl c%0d: got v=%b l=%b done=%b addr=%0d", c, s.out_valid, s.out_last, done, rom_addr);
      end
      if (c <= 6) begin
        checks++;
        if (s.out_data !== 8'(8'h40 + c)) begin
          errors++; $display("FAIL ignore_data c%0d: got %h want %h", c, s.out_data, 8'(8'h40 + c));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    s.out_ready = 1;
    kick(5'd0, 6'd6);
    tick(); tick(); tick();
    checks++;
    if (s.out_valid !== 1'b1 || s.out_data !== 8'h41) begin
      errors++; $display("FAIL mid_beat2: got v=%b %h want 1 41", s.out_valid, s.out_data);
    end
    reset = 1;
    #1;
    checks++;
    if ({s.out_valid, s.out_last, busy, done, rom_addr} !== 9'd0) begin
      errors++; $display("FAIL mid_async: got v=%b l=%b busy=%b done=%b addr=%0d want 0", s.out_valid, s.out_last, busy, done, rom_addr);
    end
    tick(); tick();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({done, s.out_valid, busy} !== 3'b000) begin
        errors++; $display("FAIL mid_quiet c%0d: got done=%b v=%b busy=%b want 000", c, done, s.out_valid, busy);
      end
      tick();
    end
    kick(5'd0, 6'd2);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if ({s.out_valid, s.out_last, done} !== {c == 3 || c == 4, c == 4, c == 5}) begin
        errors++; $display("FAIL mid_restart c%0d: got v=%b l=%b done=%b", c, s.out_valid, s.out_last, done);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (s.out_data !== 8'(8'h40 + c - 3)) begin
          errors++; $display("FAIL mid_restart_data c%0d: got %h want %h", c, s.out_data, 8'(8'h40 + c - 3));
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h40 + i);
    s.out_ready = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_stall_all();
    test_len0_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
